// File: rtl/img_row_loader.sv
// Frame loader: packs a two-pixel-per-beat grayscale stream into full rows and writes one row per memory cycle.
// Optional macro IMG_LOAD_ERR_EN adds a sticky load_err output for overrun / premature-clear events.
module img_row_loader #(
    parameter int PIX_W  = 8,
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 9
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [2*PIX_W-1:0]       in_data,
    input  logic                     clear,
    output logic                     img_we,
    output logic [ADDR_W-1:0]        img_addr,
    output logic [IMG_W*PIX_W-1:0]   img_din,
    output logic                     busy,
    output logic                     load_done
`ifdef IMG_LOAD_ERR_EN
    ,
    output logic                     load_err
`endif
);

    localparam int BEATS = IMG_W / 2;
    localparam int COL_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(BEATS - 1);
    localparam logic [ADDR_W-1:0] ROW_LAST = ADDR_W'(IMG_H - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DONE
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [COL_W-1:0]    col_cnt_reg;
    logic [ADDR_W-1:0]   row_cnt_reg;
    logic                we_reg;
    logic [ADDR_W-1:0]   addr_reg;
    logic                accept;
    logic                row_end;
    logic                frame_end;

    // Beats are taken in IDLE too, so the first beat of a frame is never lost.
    always_comb begin
        accept    = in_valid && (state_reg != ST_DONE);
        row_end   = accept && (col_cnt_reg == COL_LAST);
        frame_end = we_reg && (row_cnt_reg == ROW_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (in_valid)  state_next = ST_LOAD;
            ST_LOAD: if (frame_end) state_next = ST_DONE;
            ST_DONE: if (clear)     state_next = ST_IDLE;
            default:                state_next = ST_IDLE;
        endcase
    end

    // row_cnt advances during the write cycle so img_addr already holds the index being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_cnt_reg <= '0;
            row_cnt_reg <= '0;
            we_reg      <= 1'b0;
            addr_reg    <= '0;
        end else begin
            we_reg <= row_end;
            if (row_end) begin
                addr_reg <= row_cnt_reg;
            end
            if (frame_end) begin
                row_cnt_reg <= '0;
                col_cnt_reg <= '0;
            end else begin
                if (we_reg) begin
                    row_cnt_reg <= row_cnt_reg + ADDR_W'(1);
                end
                if (row_end) begin
                    col_cnt_reg <= '0;
                end else if (accept) begin
                    col_cnt_reg <= col_cnt_reg + COL_W'(1);
                end
            end
        end
    end

    // One register per column pair; the memory samples before a following beat can overwrite pair 0.
    genvar gi;
    generate
        for (gi = 0; gi < BEATS; gi++) begin : g_pair
            localparam logic [COL_W-1:0] IDX = COL_W'(gi);
            logic [2*PIX_W-1:0] pair_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pair_reg <= '0;
                end else if (accept && (col_cnt_reg == IDX)) begin
                    pair_reg <= in_data;
                end
            end

            assign img_din[gi*2*PIX_W +: 2*PIX_W] = pair_reg;
        end
    endgenerate

    assign img_we    = we_reg;
    assign img_addr  = addr_reg;
    assign busy      = (state_reg == ST_LOAD);
    assign load_done = (state_reg == ST_DONE);

`ifdef IMG_LOAD_ERR_EN
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if ((state_reg == ST_DONE) && clear) begin
            err_reg <= 1'b0;
        end else if (((state_reg == ST_DONE) && in_valid) ||
                     ((state_reg == ST_LOAD) && clear)) begin
            err_reg <= 1'b1;
        end
    end

    assign load_err = err_reg;
`endif

endmodule

// File: tb/tb_img_row_loader.sv
// Scoreboard bench for img_row_loader on a reduced 32x8 frame; expected rows are queued as stimulus is driven.
module tb_img_row_loader;

    localparam int PIX_W       = 8;
    localparam int IMG_W       = 32;
    localparam int IMG_H       = 8;
    localparam int ADDR_W      = 9;
    localparam int BPR         = IMG_W / 2;
    localparam int FRAME_BEATS = BPR * IMG_H;
    localparam int ROW_W       = IMG_W * PIX_W;

    logic                clk      = 1'b0;
    logic                rst_n    = 1'b0;
    logic                in_valid = 1'b0;
    logic [2*PIX_W-1:0]  in_data  = '0;
    logic                clear    = 1'b0;
    logic                img_we;
    logic [ADDR_W-1:0]   img_addr;
    logic [ROW_W-1:0]    img_din;
    logic                busy;
    logic                load_done;
`ifdef IMG_LOAD_ERR_EN
    logic                load_err;
`endif

    img_row_loader #(
        .PIX_W (PIX_W),
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_data  (in_data),
        .clear    (clear),
        .img_we   (img_we),
        .img_addr (img_addr),
        .img_din  (img_din),
        .busy     (busy),
        .load_done(load_done)
`ifdef IMG_LOAD_ERR_EN
        ,
        .load_err (load_err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ROW_W-1:0]  data;
    } exp_t;

    exp_t             sb_q[$];
    exp_t             mon_e;
    logic [ROW_W-1:0] mem [IMG_H];
    int checks    = 0;
    int errors    = 0;
    int cyc       = 0;
    int we_count  = 0;
    int last_we_cyc = 0;
    bit have_prev = 1'b0;
    bit chk_space = 1'b0;
    int wc_snap;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs, input logic [ROW_W-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [ROW_W-1:0] exp_row(input int r);
        logic [ROW_W-1:0] v;
        v = '0;
        for (int c = 0; c < IMG_W; c++) begin
            v[c*PIX_W +: PIX_W] = PIX_W'((r * IMG_W + c) % 256);
        end
        return v;
    endfunction

    // Write monitor: pops the scoreboard on every img_we and checks spacing when the frame is gap-free.
    always @(negedge clk) begin
        if (rst_n && img_we) begin
            we_count++;
            chk("we_only_in_load", {busy, load_done}, 2'b10);
            chk("sb_has_entry", (sb_q.size() > 0), 1'b1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("row_addr", img_addr, mon_e.addr);
                chk("row_data", img_din, mon_e.data);
            end
            if (chk_space && have_prev) begin
                chk("we_spacing", cyc - last_we_cyc, BPR);
            end
            if (img_addr < IMG_H) mem[img_addr] = img_din;
            last_we_cyc = cyc;
            have_prev   = 1'b1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_beat(input int k, input bit clr);
        exp_t e;
        in_valid = 1'b1;
        in_data  = {8'(2 * k + 1), 8'(2 * k)};
        clear    = clr;
        if ((k % BPR) == BPR - 1) begin
            e.addr = ADDR_W'(k / BPR);
            e.data = exp_row(k / BPR);
            sb_q.push_back(e);
        end
        tick();
        $display("beat %0d data=%04h we=%0d busy=%0d", k, in_data, img_we, busy);
    endtask

    task automatic send_frame(input int idle_pct, input int clear_at);
        have_prev = 1'b0;
        chk_space = (idle_pct == 0);
        for (int k = 0; k < FRAME_BEATS; k++) begin
            while ($urandom_range(0, 99) < idle_pct) begin
                in_valid = 1'b0;
                clear    = 1'b0;
                tick();
            end
            drive_beat(k, k == clear_at);
            if (k == 0) chk("busy_after_first", busy, 1'b1);
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        chk("we_last_row", img_we, 1'b1);
        chk("done_during_last_write", load_done, 1'b0);
        tick();
        chk("load_done_rise", load_done, 1'b1);
        chk("busy_in_done", busy, 1'b0);
        chk("we_low_in_done", img_we, 1'b0);
        chk("sb_drained", sb_q.size(), 0);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        $display("clear: load_done=%0d busy=%0d", load_done, busy);
        chk("clear_done_low", load_done, 1'b0);
        chk("clear_busy_low", busy, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_we", img_we, 1'b0);
        chk("rst_addr", img_addr, '0);
        chk("rst_din", img_din, '0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", load_done, 1'b0);
`ifdef IMG_LOAD_ERR_EN
        chk("rst_err", load_err, 1'b0);
`endif
        rst_n = 1'b1;
        tick();

        // Continuous frame, back-to-back beats across every row boundary.
        send_frame(0, -1);
        chk("row0_col01", mem[0][15:0], 16'h0100);
        chk("row1_col01", mem[1][15:0], 16'h2120);

        // Beats in DONE are ignored.
        wc_snap = we_count;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hFFFF;
            tick();
            $display("done beat %0d load_done=%0d", i, load_done);
            chk("done_holds", load_done, 1'b1);
        end
        in_valid = 1'b0;
        tick();
        chk("no_we_in_done", we_count, wc_snap);
`ifdef IMG_LOAD_ERR_EN
        chk("err_overrun", load_err, 1'b1);
`endif
        do_clear();
`ifdef IMG_LOAD_ERR_EN
        chk("err_cleared", load_err, 1'b0);
`endif

        // Same frame with random idle gaps.
        send_frame(40, -1);
        do_clear();

        // Partial frame, then asynchronous reset mid-row.
        have_prev = 1'b0;
        chk_space = 1'b0;
        for (int k = 0; k < 50; k++) drive_beat(k, 1'b0);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_din", img_din, '0);
        chk("arst_addr", img_addr, '0);
        chk("arst_we", img_we, 1'b0);
        chk("arst_sb_empty", sb_q.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        send_frame(0, -1);
        chk("row0_after_reset", mem[0], exp_row(0));
        do_clear();

        // clear during LOAD is ignored.
        send_frame(0, 40);
`ifdef IMG_LOAD_ERR_EN
        chk("err_premature_clear", load_err, 1'b1);
`endif
        do_clear();
`ifdef IMG_LOAD_ERR_EN
        chk("err_cleared2", load_err, 1'b0);
`endif

        chk("total_writes", we_count, 4 * IMG_H + 3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
